// File: rtl/loop_sequencer.sv
// Loop sequencer: steps idx from init to limit by step, each iteration lasting dwell+1 cycles.
// Latency: idx valid the cycle after start; done/wrap pulse one cycle after pass end; no backpressure (stop aborts).
module loop_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [WIDTH-1:0]   cfg_init,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic [WIDTH-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [WIDTH-1:0]   idx,
  output logic               idx_valid,
  output logic               iter_pulse,
  output logic               wrap,
  output logic               done,
  output logic               busy,
  output logic               err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_idx;
  logic [DWELL_W-1:0]   r_dwell_cnt;
  logic [WIDTH-1:0]     r_init;
  logic [WIDTH-1:0]     r_limit;
  logic [WIDTH-1:0]     r_step;
  logic [DWELL_W-1:0]   r_dwell;
  logic                 r_cont;
  logic                 r_err;
  logic                 r_done;
  logic                 r_wrap;

  logic [WIDTH:0]       w_next;
  logic                 w_iter_end;
  logic                 w_pass_end;
  logic                 w_accept;
  logic                 w_reject;
  logic                 w_empty;
  logic                 w_load;
  logic                 w_advance;
  logic                 w_restart;
  logic                 w_finish;
  logic                 w_tick;

  // One extra bit so a step that carries past 2^WIDTH-1 also ends the pass.
  assign w_next     = {1'b0, r_idx} + {1'b0, r_step};
  assign w_pass_end = w_next > {1'b0, r_limit};
  assign w_iter_end = (r_state == RUN) && (r_dwell_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_empty     = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_restart   = 1'b0;
    w_finish    = 1'b0;
    w_tick      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_accept = 1'b1;
          if (cfg_step == '0) begin
            w_reject = 1'b1;
          end else if (cfg_init > cfg_limit) begin
            w_empty = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (w_iter_end) begin
          if (!w_pass_end) begin
            w_advance = 1'b1;
          end else if (r_cont) begin
            w_restart = 1'b1;
          end else begin
            w_finish    = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_tick = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_dwell_cnt <= '0;
      r_init      <= '0;
      r_limit     <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
      r_cont      <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_done <= w_empty | w_finish;
      r_wrap <= w_restart;
      if (w_accept) begin
        r_init  <= cfg_init;
        r_limit <= cfg_limit;
        r_step  <= cfg_step;
        r_dwell <= cfg_dwell;
        r_cont  <= cont;
      end
      if (w_reject) begin
        r_err <= 1'b1;
      end else if (w_load) begin
        r_err <= 1'b0;
      end
      if (w_load) begin
        r_idx       <= cfg_init;
        r_dwell_cnt <= cfg_dwell;
      end else if (w_restart) begin
        r_idx       <= r_init;
        r_dwell_cnt <= r_dwell;
      end else if (w_advance) begin
        r_idx       <= w_next[WIDTH-1:0];
        r_dwell_cnt <= r_dwell;
      end else if (w_tick) begin
        r_dwell_cnt <= r_dwell_cnt - DWELL_ONE;
      end
    end
  end

  assign idx        = r_idx;
  assign idx_valid  = (r_state == RUN);
  assign busy       = (r_state == RUN);
  assign iter_pulse = w_iter_end;
  assign wrap       = r_wrap;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_loop_sequencer.sv
// Randomized and directed bench for loop_sequencer against an iteration-count reference model.
module tb_loop_sequencer;

  localparam int WIDTH   = 4;
  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic               cont;
  logic [WIDTH-1:0]   cfg_init;
  logic [WIDTH-1:0]   cfg_limit;
  logic [WIDTH-1:0]   cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [WIDTH-1:0]   idx;
  logic               idx_valid;
  logic               iter_pulse;
  logic               wrap;
  logic               done;
  logic               busy;
  logic               err;

  always #5 clk = ~clk;

  loop_sequencer #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .cont       (cont),
    .cfg_init   (cfg_init),
    .cfg_limit  (cfg_limit),
    .cfg_step   (cfg_step),
    .cfg_dwell  (cfg_dwell),
    .idx        (idx),
    .idx_valid  (idx_valid),
    .iter_pulse (iter_pulse),
    .wrap       (wrap),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  string phase = "reset";

  // Reference model: iteration number k and cycle-in-iteration c; idx = init + k*step.
  bit m_busy, m_cont, m_err, m_done, m_wrap;
  int m_k, m_c, m_init, m_limit, m_step, m_dwell, m_hold;

  int cyc_no, cnt_busy, cnt_iter, cnt_done, cnt_wrap, last_iter_at, done_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0d expected %0d at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  function automatic int m_idx();
    return m_busy ? (m_init + m_k * m_step) : m_hold;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cont = 0; m_err = 0; m_done = 0; m_wrap = 0;
    m_k = 0; m_c = 0; m_init = 0; m_limit = 0; m_step = 0; m_dwell = 0; m_hold = 0;
  endtask

  task automatic model_edge();
    bit nd = 0;
    bit nw = 0;
    if (!m_busy) begin
      if (start && !stop) begin
        m_init = cfg_init; m_limit = cfg_limit; m_step = cfg_step;
        m_dwell = cfg_dwell; m_cont = cont;
        if (m_step == 0) m_err = 1;
        else if (m_init > m_limit) nd = 1;
        else begin
          m_busy = 1; m_k = 0; m_c = 0; m_err = 0;
        end
      end
    end else if (stop) begin
      m_hold = m_idx();
      m_busy = 0;
    end else if (m_c == m_dwell) begin
      if (m_init + (m_k + 1) * m_step > m_limit) begin
        if (m_cont) begin
          m_k = 0; m_c = 0; nw = 1;
        end else begin
          m_hold = m_idx(); m_busy = 0; nd = 1;
        end
      end else begin
        m_k++; m_c = 0;
      end
    end else begin
      m_c++;
    end
    m_done = nd;
    m_wrap = nw;
  endtask

  task automatic check_outs();
    chk("idx",        32'(idx),        32'(m_idx()));
    chk("idx_valid",  32'(idx_valid),  32'(m_busy));
    chk("busy",       32'(busy),       32'(m_busy));
    chk("iter_pulse", 32'(iter_pulse), 32'(m_busy && (m_c == m_dwell)));
    chk("done",       32'(done),       32'(m_done));
    chk("wrap",       32'(wrap),       32'(m_wrap));
    chk("err",        32'(err),        32'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_outs();
    cyc_no++;
    if (busy) cnt_busy++;
    if (iter_pulse) begin cnt_iter++; last_iter_at = cyc_no; end
    if (done) begin cnt_done++; done_at = cyc_no; end
    if (wrap) cnt_wrap++;
  endtask

  task automatic clr_cnt();
    cnt_busy = 0; cnt_iter = 0; cnt_done = 0; cnt_wrap = 0;
    last_iter_at = 0; done_at = 0;
  endtask

  task automatic set_cfg(input int i, input int l, input int s, input int d, input bit c);
    cfg_init = WIDTH'(i); cfg_limit = WIDTH'(l); cfg_step = WIDTH'(s);
    cfg_dwell = DWELL_W'(d); cont = c;
  endtask

  task automatic scramble_cfg();
    cfg_init = WIDTH'($urandom); cfg_limit = WIDTH'($urandom);
    cfg_step = WIDTH'($urandom); cfg_dwell = DWELL_W'($urandom); cont = 1'($urandom);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic async_reset_check();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_idx",   32'(idx), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_valid", 32'(idx_valid), 0);
    chk("rst_iter",  32'(iter_pulse), 0);
    chk("rst_err",   32'(err), 0);
    check_outs();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    model_reset();
    cyc_no = 0;
    clr_cnt();
    #1;
    check_outs();
    run(2);
    rst_n = 1'b1;
    run(2);

    phase = "basic";
    set_cfg(0, 5, 1, 4, 0);
    clr_cnt();
    do_start();
    scramble_cfg();
    run(34);
    chk("busy_cycles", 32'(cnt_busy), 30);
    chk("iter_count",  32'(cnt_iter), 6);
    chk("done_count",  32'(cnt_done), 1);
    chk("done_lag",    32'(done_at - last_iter_at), 1);
    chk("idx_hold",    32'(idx), 5);

    phase = "cont";
    set_cfg(0, 5, 1, 0, 1);
    clr_cnt();
    do_start();
    set_cfg(9, 2, 0, 7, 0);
    run(14);
    chk("wrap_count", 32'(cnt_wrap), 2);
    chk("done_count", 32'(cnt_done), 0);
    chk("idx_at_15",  32'(idx), 2);
    stop = 1'b1; cyc(); stop = 1'b0;
    run(2);

    phase = "carry";
    set_cfg(12, 15, 3, 1, 0);
    clr_cnt();
    do_start();
    run(6);
    chk("iter_count", 32'(cnt_iter), 2);
    chk("done_count", 32'(cnt_done), 1);
    chk("idx_hold",   32'(idx), 15);

    phase = "step0";
    set_cfg(2, 9, 0, 1, 0);
    do_start();
    chk("err_set", 32'(err), 1);
    run(3);
    chk("busy_off", 32'(busy), 0);
    set_cfg(1, 2, 1, 0, 0);
    do_start();
    chk("err_clr", 32'(err), 0);
    run(4);
    phase = "empty";
    set_cfg(7, 3, 1, 0, 0);
    clr_cnt();
    do_start();
    run(3);
    chk("iter_count", 32'(cnt_iter), 0);
    chk("done_count", 32'(cnt_done), 1);
    chk("idx_keep",   32'(idx), 2);

    phase = "stop";
    set_cfg(0, 9, 1, 2, 0);
    clr_cnt();
    do_start();
    run(6);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("idx_stop",  32'(idx), 2);
    chk("busy_stop", 32'(busy), 0);
    run(3);
    chk("done_count", 32'(cnt_done), 0);
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("start_blocked", 32'(busy), 0);

    phase = "reset";
    set_cfg(0, 15, 1, 3, 1);
    do_start();
    run(9);
    async_reset_check();
    set_cfg(3, 5, 2, 0, 0);
    do_start();
    chk("first_idx", 32'(idx), 3);
    run(3);

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom % 3) == 0;
      stop  = ($urandom % 25) == 0;
      scramble_cfg();
      cfg_dwell = DWELL_W'($urandom % 4);
      if (($urandom % 400) == 0) async_reset_check();
      else cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/loop_sequencer.md
LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the loop index width in bits.
REQ-002 SHALL have parameter DWELL_W, default 4, giving the dwell counter width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  a level sampled each cycle that begins a loop when the block is idle.
REQ-006 SHALL have port stop  input  1  synchronous abort.
REQ-007 SHALL have port cont  input  1  continuous mode (restart after the last iteration); latched at start.
REQ-008 SHALL have port cfg_init  input  WIDTH  loop start value.
REQ-009 SHALL have port cfg_limit  input  WIDTH  inclusive upper bound, i.e. loop while idx <= limit.
REQ-010 SHALL have port cfg_step  input  WIDTH  increment per iteration.
REQ-011 SHALL have port cfg_dwell  input  DWELL_W  extra cycles per iteration; each iteration lasts dwell+1 cycles.
REQ-012 SHALL have port idx  output  WIDTH  current loop index.
REQ-013 SHALL have port idx_valid  output  1  high while an iteration body is active.
REQ-014 SHALL have port iter_pulse  output  1  one-cycle pulse on the last cycle of each iteration.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse when continuous mode restarts at init.
REQ-016 SHALL have port done  output  1  one-cycle pulse on normal loop completion.
REQ-017 SHALL have port busy  output  1  high in any non-IDLE state.
REQ-018 SHALL have port err  output  1  sticky flag for rejected configuration; cleared by the next accepted start or by reset.

Function
REQ-019 SHALL implement a state machine with two states: IDLE and RUN.
REQ-020 SHALL, in IDLE with start=1 and stop=0, latch cfg_* and cont on that edge; later cfg changes SHALL have no effect until the next start.
REQ-021 SHALL, on a start with cfg_step==0, set err=1, stay in IDLE and not pulse done.
REQ-022 SHALL, on a start with cfg_init > cfg_limit (unsigned), pulse done on the next cycle, stay in IDLE, execute zero iterations and leave idx unchanged.
REQ-023 SHALL, on any other start, load idx=cfg_init and dwell counter=cfg_dwell, clear err and enter RUN; idx_valid=1 from the next cycle.
REQ-024 SHALL, in RUN, decrement the dwell counter each cycle; the iteration ends on the cycle the counter equals 0, and iter_pulse SHALL be high on that cycle.
REQ-025 SHALL, at iteration end, compute next=idx+step in WIDTH+1 bits; if the carry is set or next > limit, the pass ends, otherwise idx<=next[WIDTH-1:0] and the dwell counter reloads.
REQ-026 SHALL, at pass end with cont=0, pulse done on the following cycle, return to IDLE and hold idx at the last executed value.
REQ-027 SHALL, at pass end with cont=1, set idx<=init, reload dwell, pulse wrap on the following cycle and remain in RUN with no idle gap.
REQ-028 SHALL give stop priority over all other events: stop=1 in RUN forces IDLE on the next edge with no done or wrap pulse and idx held; stop=1 in IDLE blocks start.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL never allow idx to wrap past 2^WIDTH-1 within a pass; an overflowing next value SHALL end the pass per REQ-025.
REQ-031 SHALL, when limit equals init, execute exactly one iteration.

Reset
REQ-032 SHALL, while rst_n=0, immediately force state=IDLE, idx=0, dwell counter=0 and idx_valid=iter_pulse=wrap=done=busy=err=0, including mid-RUN.
REQ-033 SHALL, after rst_n deasserts, ignore all prior latched configuration, and the first accepted start SHALL behave per REQ-020..023.

Verification
REQ-034 SHALL cover: init=0, limit=5, step=1, dwell=4, cont=0 -> idx 0,1,2,3,4,5 each valid for 5 cycles, six iter_pulses, done one cycle after the sixth, 30 busy cycles.
REQ-035 SHALL cover: init=0, limit=5, step=1, dwell=0, cont=1, run 15 cycles -> idx 0..5 twice, then 0,1,2; wrap pulses after cycles 6 and 12; no done.
REQ-036 SHALL cover: init=12, limit=15, step=3, WIDTH=4 -> idx 12 then 15; 15+3 carries out, the pass ends and done pulses; idx holds 15.
REQ-037 SHALL cover: step=0 -> err=1, busy stays 0; then a valid start -> err clears; also init=7, limit=3 -> done only, zero iter_pulses.
REQ-038 SHALL cover: stop asserted in the third iteration -> IDLE next cycle, idx=2, no done; start and stop together in IDLE -> remains IDLE.
REQ-039 SHALL cover: rst_n pulsed low mid-RUN -> all outputs 0 asynchronously; start after release -> clean loop from cfg_init.
